// File: rtl/spe_fire_pkg.sv
// Shared definitions for the spiking-neuron fire engine: accumulator width,
// router packet field positions, opcode helpers and the controller states.
package spe_fire_pkg;

  localparam int SUM_WIDTH = 13;
  localparam logic [SUM_WIDTH-1:0] SUM_MAX = '1;

  // Router packet layout: [32:29] destination, [28:25] opcode, [24:0] data
  localparam int PKT_WIDTH = 33;
  localparam int DEST_HI   = 32;
  localparam int DEST_LO   = 29;
  localparam int OP_HI     = 28;
  localparam int OP_LO     = 25;
  localparam int DATA_HI   = 24;
  localparam int DATA_LO   = 0;
  localparam int DATA_WIDTH = DATA_HI - DATA_LO + 1;

  localparam logic [3:0] OP_TIMESTEP_DONE = 4'd15;

  typedef enum logic [2:0] {
    ST_ACCUM,
    ST_REQ,
    ST_WAIT_RES,
    ST_FIRE,
    ST_SEND,
    ST_TS_WAIT,
    ST_DONE
  } state_t;

  // Opcode this SPE uses when delivering a fired neuron to output memory
  function automatic logic [3:0] send_opcode(input int spe_idx);
    return 4'(2 * spe_idx);
  endfunction

  // Opcode this SPE uses when asking for the previous timestep's residue
  function automatic logic [3:0] req_opcode(input int spe_idx);
    return 4'(2 * spe_idx + 1);
  endfunction

endpackage

// File: rtl/spe_fire_if.sv
// Router-side handshake bundle: one inbound and one outbound packet channel.
interface spe_fire_if;
  import spe_fire_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [PKT_WIDTH-1:0] in_packet;
  logic                 out_valid;
  logic                 out_ready;
  logic [PKT_WIDTH-1:0] out_packet;

  // Router side: drives inbound packets and accepts outbound ones
  modport master (
    output in_valid, in_packet, out_ready,
    input  in_ready, out_valid, out_packet
  );

  // SPE side
  modport slave (
    input  in_valid, in_packet, out_ready,
    output in_ready, out_valid, out_packet
  );
endinterface

// File: rtl/spe_sat_add.sv
// Unsigned saturating adder: clamps at the all-ones value instead of wrapping.
module spe_sat_add
  import spe_fire_pkg::*;
(
  input  logic [SUM_WIDTH-1:0] a,
  input  logic [SUM_WIDTH-1:0] b,
  output logic [SUM_WIDTH-1:0] sum
);

  logic [SUM_WIDTH:0] full_sum;

  // Carry out of the top bit means the true sum exceeds the range
  assign full_sum = {1'b0, a} + {1'b0, b};
  assign sum      = full_sum[SUM_WIDTH] ? SUM_MAX : full_sum[SUM_WIDTH-1:0];

endmodule

// File: rtl/spe_fire.sv
// Neuron fire engine: accumulates partial sums per neuron, optionally folds in
// the previous timestep's residue, fires against a threshold and ships the
// spike/residue to output memory; sequences two timesteps.
module spe_fire
  import spe_fire_pkg::*;
#(
  parameter int SPE_IDX     = 0,
  parameter int OMEM_ID     = 11,
  parameter int THRESHOLD   = 64,
  parameter int NUM_PSUM    = 5,
  parameter int NUM_NEURONS = 89
) (
  input  logic        clk,
  input  logic        reset,
  spe_fire_if.slave   bus,
  output logic [1:0]  ts,
  output logic        done,
  output logic        err
);

  localparam int PSUM_CNT_W   = $clog2(NUM_PSUM + 1);
  localparam int NEURON_CNT_W = $clog2(NUM_NEURONS + 1);
  localparam int PAD_W        = DATA_WIDTH - SUM_WIDTH - 1;

  localparam logic [SUM_WIDTH-1:0]    THRESH      = SUM_WIDTH'(THRESHOLD);
  localparam logic [PSUM_CNT_W-1:0]   LAST_PSUM   = PSUM_CNT_W'(NUM_PSUM - 1);
  localparam logic [NEURON_CNT_W-1:0] LAST_NEURON = NEURON_CNT_W'(NUM_NEURONS - 1);

  state_t                  state_reg;
  logic [SUM_WIDTH-1:0]    potential_reg;
  logic [PSUM_CNT_W-1:0]   psum_cnt_reg;
  logic [NEURON_CNT_W-1:0] neuron_cnt_reg;
  logic [1:0]              ts_reg;
  logic                    done_reg;
  logic                    err_reg;
  logic                    out_valid_reg;
  logic [PKT_WIDTH-1:0]    out_packet_reg;

  logic [3:0]           in_op;
  logic [SUM_WIDTH-1:0] in_data;
  logic                 in_accept;
  logic                 out_accept;
  logic                 is_ts_done_op;
  logic [SUM_WIDTH-1:0] add_sum;
  logic                 spike;
  logic [SUM_WIDTH-1:0] residue;
  logic                 unused_in_bits;

  assign in_op         = bus.in_packet[OP_HI:OP_LO];
  assign in_data       = bus.in_packet[DATA_LO+SUM_WIDTH-1:DATA_LO];
  assign in_accept     = bus.in_valid & bus.in_ready;
  assign out_accept    = out_valid_reg & bus.out_ready;
  assign is_ts_done_op = (in_op == OP_TIMESTEP_DONE);

  // Destination and the upper data bits carry nothing this block consumes
  assign unused_in_bits = ^{bus.in_packet[DEST_HI:DEST_LO],
                            bus.in_packet[DATA_HI:DATA_LO+SUM_WIDTH]};

  // Single adder shared by psum accumulation and residue fold-in
  spe_sat_add u_sat_add (
    .a   (potential_reg),
    .b   (in_data),
    .sum (add_sum)
  );

  // Threshold comparison evaluated on the settled potential during FIRE
  assign spike   = (potential_reg >= THRESH);
  assign residue = spike ? (potential_reg - THRESH) : potential_reg;

  // Inbound acceptance follows state only, so it can never overlap out_valid
  assign bus.in_ready = (state_reg == ST_ACCUM)   || (state_reg == ST_WAIT_RES) ||
                        (state_reg == ST_TS_WAIT) || (state_reg == ST_DONE);

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_packet = out_packet_reg;
  assign ts             = ts_reg;
  assign done           = done_reg;
  assign err            = err_reg;

  // Controller FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_ACCUM;
      potential_reg  <= '0;
      psum_cnt_reg   <= '0;
      neuron_cnt_reg <= '0;
      ts_reg         <= 2'd1;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_packet_reg <= '0;
    end else begin
      case (state_reg)
        ST_ACCUM: begin
          if (in_accept) begin
            if (is_ts_done_op) begin
              err_reg <= 1'b1;
            end else begin
              potential_reg <= add_sum;
              psum_cnt_reg  <= psum_cnt_reg + 1'b1;
              if (psum_cnt_reg == LAST_PSUM) begin
                if (ts_reg == 2'd1) begin
                  state_reg <= ST_FIRE;
                end else begin
                  state_reg      <= ST_REQ;
                  out_valid_reg  <= 1'b1;
                  out_packet_reg <= {4'(SPE_IDX), req_opcode(SPE_IDX),
                                     {DATA_WIDTH{1'b0}}};
                end
              end
            end
          end
        end

        ST_REQ: begin
          if (out_accept) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_WAIT_RES;
          end
        end

        ST_WAIT_RES: begin
          if (in_accept) begin
            if (is_ts_done_op) begin
              err_reg <= 1'b1;
            end else begin
              potential_reg <= add_sum;
              state_reg     <= ST_FIRE;
            end
          end
        end

        ST_FIRE: begin
          out_valid_reg  <= 1'b1;
          out_packet_reg <= {4'(OMEM_ID), send_opcode(SPE_IDX),
                             {PAD_W{1'b0}}, residue, spike};
          state_reg      <= ST_SEND;
        end

        ST_SEND: begin
          if (out_accept) begin
            out_valid_reg  <= 1'b0;
            potential_reg  <= '0;
            psum_cnt_reg   <= '0;
            neuron_cnt_reg <= neuron_cnt_reg + 1'b1;
            state_reg      <= (neuron_cnt_reg == LAST_NEURON) ? ST_TS_WAIT : ST_ACCUM;
          end
        end

        ST_TS_WAIT: begin
          if (in_accept) begin
            if (!is_ts_done_op) begin
              err_reg <= 1'b1;
            end else if (ts_reg == 2'd1) begin
              ts_reg         <= 2'd2;
              neuron_cnt_reg <= '0;
              state_reg      <= ST_ACCUM;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          // Terminal: everything offered is swallowed silently
        end

        default: state_reg <= ST_ACCUM;
      endcase
    end
  end

endmodule
